// File: rtl/video_in_pkg.sv
// Shared definitions for the video input capture block: capture FSM states
// and the default geometry / buffer sizing.
package video_in_pkg;

  typedef enum logic [1:0] {
    ST_SYNC          = 2'd0,
    ST_WAIT_FRAME    = 2'd1,
    ST_IN_LINE       = 2'd2,
    ST_BETWEEN_LINES = 2'd3
  } state_e;

  localparam int DEF_PIX_W      = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_H_PIXELS   = 640;
  localparam int DEF_V_LINES    = 480;
  localparam int FRAME_CNT_W    = 16;

endpackage

// File: rtl/video_in_capture_if.sv
// Tagged pixel stream with valid/ready handshake; the capture block is the
// master, the downstream consumer is the slave.
interface video_in_capture_if
  import video_in_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);

  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_data,
    output pix_sof,
    output pix_eol,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_sof,
    input  pix_eol,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/video_fifo.sv
// Synchronous FIFO for tagged pixels. A write into a full FIFO is accepted
// when a read happens in the same cycle; head word reads as zero when empty.
module video_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_rd      = i_rd_en & ~o_empty;
  assign w_wr      = i_wr_en & (~o_full | w_rd);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/video_in_capture.sv
// Camera sensor capture: frame/line synchronisation, one input register
// stage, geometry checking and a buffered tagged pixel stream output.
module video_in_capture
  import video_in_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   frame_valid,
  input  logic                   line_valid,
  input  logic [PIX_W-1:0]       pixel_in,
  video_in_capture_if.master     pix_if,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   geom_err,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int HCW = $clog2(H_PIXELS + 1) + 1;
  localparam int VCW = $clog2(V_LINES + 1) + 1;
  localparam int FW  = PIX_W + 2;

  state_e                 r_state;
  state_e                 w_next_state;
  logic                   w_act;
  logic                   w_cap;
  logic                   w_cap_sof;
  logic                   w_line_end;
  logic                   w_frame_end;
  logic [HCW-1:0]         r_pix_cnt;
  logic [HCW-1:0]         w_pix_cnt_nxt;
  logic [HCW-1:0]         w_pix_cnt_inc;
  logic [VCW-1:0]         r_line_cnt;
  logic [VCW-1:0]         w_line_cnt_nxt;
  logic [VCW-1:0]         w_line_cnt_inc;
  logic                   r_pend;
  logic                   r_pend_sof;
  logic [PIX_W-1:0]       r_pend_data;
  logic [FW-1:0]          w_wr_word;
  logic [FW-1:0]          w_rd_word;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_rd;
  logic                   w_ovf_evt;
  logic                   w_geom_evt;
  logic                   r_overflow;
  logic                   r_geom_err;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  assign w_act          = frame_valid & line_valid;
  assign w_pix_cnt_inc  = (r_pix_cnt == {HCW{1'b1}}) ? r_pix_cnt : r_pix_cnt + HCW'(1);
  assign w_line_cnt_inc = (r_line_cnt == {VCW{1'b1}}) ? r_line_cnt : r_line_cnt + VCW'(1);

  // Next-state, capture strobe and line/frame boundary detection.
  always_comb begin
    w_next_state   = r_state;
    w_cap          = 1'b0;
    w_cap_sof      = 1'b0;
    w_line_end     = 1'b0;
    w_frame_end    = 1'b0;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_line_cnt_nxt = r_line_cnt;
    case (r_state)
      ST_SYNC: begin
        if (!frame_valid) begin
          w_next_state = ST_WAIT_FRAME;
        end else begin
          w_next_state = ST_SYNC;
        end
      end
      ST_WAIT_FRAME: begin
        if (w_act) begin
          w_next_state   = ST_IN_LINE;
          w_cap          = 1'b1;
          w_cap_sof      = 1'b1;
          w_pix_cnt_nxt  = HCW'(1);
          w_line_cnt_nxt = VCW'(1);
        end else begin
          w_next_state = ST_WAIT_FRAME;
        end
      end
      ST_IN_LINE: begin
        if (!frame_valid) begin
          w_next_state = ST_WAIT_FRAME;
          w_line_end   = 1'b1;
          w_frame_end  = 1'b1;
        end else if (!line_valid) begin
          w_next_state = ST_BETWEEN_LINES;
          w_line_end   = 1'b1;
        end else begin
          w_cap         = 1'b1;
          w_pix_cnt_nxt = w_pix_cnt_inc;
        end
      end
      ST_BETWEEN_LINES: begin
        if (!frame_valid) begin
          w_next_state = ST_WAIT_FRAME;
          w_frame_end  = 1'b1;
        end else if (line_valid) begin
          w_next_state   = ST_IN_LINE;
          w_cap          = 1'b1;
          w_pix_cnt_nxt  = HCW'(1);
          w_line_cnt_nxt = w_line_cnt_inc;
        end else begin
          w_next_state = ST_BETWEEN_LINES;
        end
      end
      default: begin
        w_next_state = ST_SYNC;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Input stage: a captured pixel waits one cycle so that the following
  // sample tells whether it was the last one of its line.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_pend      <= 1'b0;
      r_pend_sof  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_pend      <= w_cap;
      r_pend_sof  <= w_cap_sof;
      r_pend_data <= pixel_in;
    end
  end

  // Per-line pixel and per-frame line counters.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_line_cnt <= w_line_cnt_nxt;
    end
  end

  assign w_wr_word  = {r_pend_data, r_pend_sof, ~w_act};
  assign w_rd       = pix_if.pix_valid & pix_if.pix_ready;
  assign w_ovf_evt  = r_pend & w_full & ~w_rd;
  assign w_geom_evt = (w_line_end & (r_pix_cnt != HCW'(H_PIXELS))) |
                      (w_frame_end & (r_line_cnt != VCW'(V_LINES)));

  video_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .i_wr_en   (r_pend),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_word),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Sticky error flags (a new error beats a clear) and completed-frame count.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_overflow  <= 1'b0;
      r_geom_err  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_geom_evt) begin
        r_geom_err <= 1'b1;
      end else if (err_clr) begin
        r_geom_err <= 1'b0;
      end
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign pix_if.pix_valid = ~w_empty;
  assign {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol} = w_rd_word;
  assign overflow    = r_overflow;
  assign geom_err    = r_geom_err;
  assign frame_count = r_frame_cnt;

endmodule

// File: tb/tb_video_in_capture.sv
// Scoreboard bench for video_in_capture: frames are described by line count
// and length, expected tagged pixels are queued, a monitor pops on transfers.
module tb_video_in_capture;

  logic        clk = 1'b0;
  logic        RST;
  logic        frame_valid;
  logic        line_valid;
  logic [7:0]  pixel_in;
  logic        err_clr;
  logic        overflow;
  logic        geom_err;
  logic [15:0] frame_count;
  logic        ready_fixed;
  logic        rnd_ready;
  logic        rnd_mode;
  logic        mon_en;
  logic        stall_prev;
  logic [9:0]  stall_word;
  logic [9:0]  exp_q[$];
  int          n_cmp;
  int          n_fail;
  int          pix_seq;

  video_in_capture_if #(.PIX_W(8)) vif ();

  video_in_capture #(
    .PIX_W      (8),
    .FIFO_DEPTH (4),
    .H_PIXELS   (4),
    .V_LINES    (3)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pixel_in    (pixel_in),
    .pix_if      (vif),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .geom_err    (geom_err),
    .frame_count (frame_count)
  );

  assign vif.pix_ready = rnd_mode ? rnd_ready : ready_fixed;

  always #5 clk = ~clk;

  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    logic [9:0] word;
    logic [9:0] e;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      word = {vif.pix_data, vif.pix_sof, vif.pix_eol};
      if (mon_en && !RST) begin
        if (stall_prev) begin
          chk("stall_valid", 32'(vif.pix_valid), 32'd1);
          chk("stall_word", 32'(word), 32'(stall_word));
        end
        if (vif.pix_valid && vif.pix_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected no output", word);
          end else begin
            e = exp_q.pop_front();
            chk("out_word{data,sof,eol}", 32'(word), 32'(e));
          end
        end
        stall_prev = vif.pix_valid && !vif.pix_ready;
        stall_word = word;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d expected pixels outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic sensor(input logic fv, input logic lv, input logic [7:0] px);
    frame_valid = fv;
    line_valid  = lv;
    pixel_in    = px;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic fv);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      sensor(fv, 1'b0, 8'h00);
      k++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    sensor(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input int nl, input int ll, input int keep,
                            input bit rnd, input bit lat, input bit drn);
    int         pushed = 0;
    int         gap;
    logic [7:0] px;
    logic       sof_b;
    logic       eol_b;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < ll; p++) begin
        if (rnd) begin
          px = 8'($urandom_range(0, 255));
        end else begin
          pix_seq++;
          px = 8'(pix_seq);
        end
        sof_b = (l == 0) && (p == 0);
        eol_b = (p == ll - 1);
        if (pushed < keep) begin
          exp_q.push_back({px, sof_b, eol_b});
          pushed++;
        end
        sensor(1'b1, 1'b1, px);
        if (lat && l == 0 && p == 0) begin
          @(negedge clk);
          chk("latency_valid_after_1_edge", 32'(vif.pix_valid), 32'd0);
        end
        if (lat && l == 0 && p == 1) begin
          @(negedge clk);
          chk("latency_valid_after_2_edges", 32'(vif.pix_valid), 32'd1);
        end
      end
      gap = rnd ? int'($urandom_range(1, 3)) : 1;
      repeat (gap) sensor(1'b1, 1'b0, 8'h00);
      if (drn) drain(1'b1);
    end
    sensor(1'b0, 1'b0, 8'h00);
    sensor(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_status(input string tag, input logic ovf, input logic geo, input int fc);
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, "_geom_err"}, 32'(geom_err), 32'(geo));
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(fc));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; pix_seq = 0;
    RST = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; pixel_in = 8'h00;
    err_clr = 1'b0; ready_fixed = 1'b1; rnd_mode = 1'b0; mon_en = 1'b0;
    repeat (3) sensor(1'b0, 1'b0, 8'h00);
    chk("reset_pix_valid", 32'(vif.pix_valid), 32'd0);
    chk("reset_pix_data", 32'(vif.pix_data), 32'd0);
    chk("reset_pix_sof", 32'(vif.pix_sof), 32'd0);
    chk("reset_pix_eol", 32'(vif.pix_eol), 32'd0);
    chk_status("reset", 1'b0, 1'b0, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    sensor(1'b0, 1'b0, 8'h00);

    // 4x3 frame, pixels 1..12, ready held high, latency check on the first pixel.
    pix_seq = 0;
    send_frame(3, 4, 99, 1'b0, 1'b1, 1'b0);
    drain(1'b0);
    chk_status("frame4x3", 1'b0, 1'b0, 1);

    // Reset in the middle of a frame: buffered pixels discarded, partial frame ignored.
    ready_fixed = 1'b0;
    sensor(1'b1, 1'b1, 8'h55);
    sensor(1'b1, 1'b1, 8'h56);
    sensor(1'b1, 1'b1, 8'h57);
    RST = 1'b1;
    sensor(1'b1, 1'b1, 8'h58);
    sensor(1'b1, 1'b1, 8'h59);
    chk("midrst_pix_valid", 32'(vif.pix_valid), 32'd0);
    chk("midrst_pix_data", 32'(vif.pix_data), 32'd0);
    chk_status("midrst", 1'b0, 1'b0, 0);
    RST = 1'b0;
    ready_fixed = 1'b1;
    sensor(1'b1, 1'b1, 8'h5A);
    sensor(1'b1, 1'b1, 8'h5B);
    sensor(1'b1, 1'b0, 8'h00);
    repeat (4) sensor(1'b1, 1'b1, 8'h5C);
    sensor(1'b1, 1'b0, 8'h00);
    sensor(1'b0, 1'b0, 8'h00);
    sensor(1'b0, 1'b0, 8'h00);
    chk("midrst_partial_ignored", 32'(vif.pix_valid), 32'd0);
    pix_seq = 100;
    send_frame(3, 4, 99, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    chk_status("after_midrst", 1'b0, 1'b0, 1);

    // Short lines (3 pixels, H=4) with the correct number of lines.
    pix_seq = 20;
    send_frame(3, 3, 99, 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    chk_status("short_line", 1'b0, 1'b1, 2);
    pulse_clr();
    chk("short_line_cleared", 32'(geom_err), 32'd0);

    // Overflow: depth 4, no ready, 6-pixel line; pixels 5 and 6 are lost.
    ready_fixed = 1'b0;
    pix_seq = 0;
    send_frame(1, 6, 4, 1'b0, 1'b0, 1'b0);
    chk("ovf_head_valid", 32'(vif.pix_valid), 32'd1);
    chk("ovf_head_data", 32'(vif.pix_data), 32'd1);
    chk("ovf_head_sof", 32'(vif.pix_sof), 32'd1);
    chk_status("ovf", 1'b1, 1'b1, 3);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_geom_cleared", 32'(geom_err), 32'd0);
    ready_fixed = 1'b1;
    drain(1'b0);

    // Full FIFO with a read and a write in the same cycle.
    ready_fixed = 1'b0;
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back({8'(p + 1), 1'(p == 0), 1'(p == 4)});
      sensor(1'b1, 1'b1, 8'(p + 1));
    end
    ready_fixed = 1'b1;
    sensor(1'b1, 1'b0, 8'h00);
    chk("full_rw_overflow", 32'(overflow), 32'd0);
    sensor(1'b0, 1'b0, 8'h00);
    sensor(1'b0, 1'b0, 8'h00);
    drain(1'b0);
    chk_status("full_rw", 1'b0, 1'b1, 4);
    pulse_clr();

    // Three 4x3 frames with random data, random blanking and random backpressure.
    rnd_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(3, 4, 99, 1'b1, 1'b0, 1'b1);
    end
    drain(1'b0);
    rnd_mode = 1'b0;
    sensor(1'b0, 1'b0, 8'h00);
    chk_status("random", 1'b0, 1'b0, 7);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/video_in_capture.md
VIDEO_IN_CAPTURE -- requirements
Module: video_in_capture

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel bit width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffer words (power of 2, >=4).
REQ-003 SHALL have parameter H_PIXELS, default 640, expected pixels per line.
REQ-004 SHALL have parameter V_LINES, default 480, expected lines per frame.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 frame_valid  in  1  sensor frame-active.
REQ-008 line_valid  in  1  sensor line-active; pixel valid when frame_valid&line_valid.
REQ-009 pixel_in  in  PIX_W  sensor pixel.
REQ-010 pix_data  out  PIX_W  buffered pixel.
REQ-011 pix_sof / pix_eol  out  1 each  tag: first pixel of frame / last pixel of line.
REQ-012 pix_valid  out  1; pix_ready  in  1  -- output handshake, transfer when both high.
REQ-013 err_clr  in  1  clears sticky flags.
REQ-014 overflow, geom_err  out  1 each  sticky error flags.
REQ-015 frame_count  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-016 FSM states SYNC, WAIT_FRAME, IN_LINE, BETWEEN_LINES; SHALL enter SYNC on reset.
REQ-017 SYNC -> WAIT_FRAME only after one cycle with frame_valid=0 (no capture of a partial frame).
REQ-018 WAIT_FRAME -> IN_LINE on frame_valid&line_valid; first pixel tagged sof.
REQ-019 IN_LINE -> BETWEEN_LINES on line_valid falling with frame_valid=1; -> WAIT_FRAME on frame_valid falling.
REQ-020 BETWEEN_LINES -> IN_LINE on line_valid rising; -> WAIT_FRAME on frame_valid falling, frame_count+1.
REQ-021 Input SHALL pass one register stage; pixel sampled at edge t written to FIFO at edge t+1, pix_valid high in cycle after edge t+1 if FIFO was empty (latency 2).
REQ-022 eol SHALL be attached to the last registered pixel of a line (detected by line_valid drop, written with that pixel).
REQ-023 pix_data/sof/eol SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-024 FIFO full and write pending without same-cycle read: pixel dropped, overflow set.
REQ-025 FIFO full with simultaneous read and write: both occur, no overflow.
REQ-026 FIFO empty with write: no same-cycle bypass; pix_valid rises next cycle.
REQ-027 Pixel counter per line SHALL compare to H_PIXELS at line end; mismatch sets geom_err.
REQ-028 Line counter per frame SHALL compare to V_LINES at frame end; mismatch sets geom_err.
REQ-029 frame_valid falling mid-line SHALL close line (eol on last pixel) and frame, and set geom_err if counts mismatch.
REQ-030 err_clr SHALL clear flags next edge; an error in the same cycle as err_clr wins (flag stays set).
REQ-031 Counters SHALL be width $clog2(max+1) of their parameter plus 1, saturating, no wrap.

Reset
REQ-032 RST SHALL force, at next edge: FSM=SYNC, FIFO empty, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, overflow=0, geom_err=0, frame_count=0, counters=0.
REQ-033 RST mid-frame SHALL discard buffered pixels; capture resumes only per REQ-017.

Structure
REQ-034 Package video_in_pkg SHALL hold FSM state enum and default parameter constants.
REQ-035 Buffer SHALL be sub-module video_fifo, parametrised width PIX_W+2 (data, sof, eol) and FIFO_DEPTH, with full/empty outputs.

Verification
REQ-036 4x3 frame (H_PIXELS=4,V_LINES=3), pix_ready=1, pixels 1..12 -> 12 outputs in order, sof on 1, eol on 4,8,12, first pix_valid 2 cycles after pixel 1, frame_count=1, no errors.
REQ-037 Reset released mid-frame -> no output until frame_valid low then new frame; first output has sof.
REQ-038 FIFO_DEPTH=4, pix_ready=0, 6 pixels -> first 4 held (values 1..4), overflow=1; err_clr -> overflow=0.
REQ-039 Line of 3 pixels with H_PIXELS=4 -> geom_err=1, eol on 3rd pixel.
REQ-040 Full FIFO, pix_ready=1 with new pixel same cycle -> pixel accepted, overflow stays 0.
REQ-041 Random pix_ready backpressure over 3 frames -> data/tags stable while stalled, sequence intact.
